// File: rtl/bp_counter_update_ctrl.sv
// Branch-predictor counter RAM sequencer.
// Walks the RAM to INIT_VAL after reset/clear, serves fetch lookups on the read
// port with priority, and applies queued saturating counter updates as
// read-modify-write sequences through the single write port.
module bp_counter_update_ctrl #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned INDEX    = 6,
    parameter int unsigned CTRW     = 2,
    parameter int unsigned INIT_VAL = 2,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             fetch_req_i,
    input  logic [INDEX-1:0] fetch_idx_i,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic [CTRW-1:0]  pred_ctr_o,
    input  logic             upd_valid_i,
    output logic             upd_ready_o,
    input  logic [INDEX-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic [INDEX-1:0] ram_addr0_o,
    input  logic [CTRW-1:0]  ram_data0_i,
    output logic [INDEX-1:0] ram_addr0wr_o,
    output logic [CTRW-1:0]  ram_data0wr_o,
    output logic             ram_we0_o,
    output logic             init_done_o
);

    localparam int unsigned QPTRW = $clog2(QDEPTH);
    localparam logic [QPTRW:0]    Q_FULL   = (QPTRW+1)'(QDEPTH);
    localparam logic [INDEX-1:0]  LAST_IDX = INDEX'(DEPTH - 1);
    localparam logic [CTRW-1:0]   CTR_MAX  = '1;
    localparam logic [CTRW-1:0]   CTR_INIT = CTRW'(INIT_VAL);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    state_t           state;
    logic [INDEX-1:0] init_ptr;
    logic [CTRW-1:0]  ctr_q;

    logic [INDEX-1:0] q_idx   [QDEPTH];
    logic             q_taken [QDEPTH];
    logic [QPTRW-1:0] rd_ptr;
    logic [QPTRW-1:0] wr_ptr;
    logic [QPTRW:0]   count;
    logic [QPTRW:0]   count_nxt;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [INDEX-1:0] head_idx;
    logic             head_taken;

    // Saturating counter step: never wraps at either end.
    function automatic logic [CTRW-1:0] sat(input logic [CTRW-1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? ctr : ctr + CTRW'(1);
        end
        return (ctr == '0) ? ctr : ctr - CTRW'(1);
    endfunction

    assign full        = (count == Q_FULL);
    assign empty       = (count == '0);
    assign upd_ready_o = init_done_o & ~full;
    assign push        = upd_valid_i & upd_ready_o;
    assign pop         = (state == S_WR);
    assign head_idx    = q_idx[rd_ptr];
    assign head_taken  = q_taken[rd_ptr];

    // Fetch owns the read port whenever it asks; otherwise the queue head is read.
    assign ram_addr0_o  = fetch_req_i ? fetch_idx_i : head_idx;
    assign pred_valid_o = fetch_req_i & init_done_o;
    assign pred_ctr_o   = ram_data0_i;
    assign pred_taken_o = ram_data0_i[CTRW-1];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (QPTRW+1)'(1);
            2'b01:   count_nxt = count - (QPTRW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Write port decode: init walk or the write half of an update; quiet in reset.
    always_comb begin
        ram_we0_o     = 1'b0;
        ram_addr0wr_o = init_ptr;
        ram_data0wr_o = CTR_INIT;
        if (reset) begin
            if (state == S_INIT) begin
                ram_we0_o = 1'b1;
            end else if (state == S_WR) begin
                ram_we0_o     = 1'b1;
                ram_addr0wr_o = head_idx;
                ram_data0wr_o = sat(ctr_q, head_taken);
            end
        end
    end

    // Update queue payload storage.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr]   <= upd_idx_i;
            q_taken[wr_ptr] <= upd_taken_i;
        end
    end

    // Update queue pointers; clear drops everything queued.
    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + QPTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + QPTRW'(1);
            count <= count_nxt;
        end
    end

    // Sequencer: init walk, then read-modify-write of queued updates.
    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            state       <= S_INIT;
            init_ptr    <= '0;
            init_done_o <= 1'b0;
            ctr_q       <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    init_ptr <= init_ptr + INDEX'(1);
                    if (init_ptr == LAST_IDX) begin
                        state       <= S_IDLE;
                        init_done_o <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!empty) state <= S_RD;
                end
                S_RD: begin
                    if (!fetch_req_i) begin
                        ctr_q <= ram_data0_i;
                        state <= S_WR;
                    end
                end
                S_WR: begin
                    state <= (count_nxt != '0) ? S_RD : S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_counter_update_ctrl.sv
// Directed bench for bp_counter_update_ctrl with a behavioural counter RAM.
module tb_bp_counter_update_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_i;
    logic       fetch_req_i;
    logic [5:0] fetch_idx_i;
    logic       pred_valid_o;
    logic       pred_taken_o;
    logic [1:0] pred_ctr_o;
    logic       upd_valid_i;
    logic       upd_ready_o;
    logic [5:0] upd_idx_i;
    logic       upd_taken_i;
    logic [5:0] ram_addr0_o;
    logic [1:0] ram_data0_i;
    logic [5:0] ram_addr0wr_o;
    logic [1:0] ram_data0wr_o;
    logic       ram_we0_o;
    logic       init_done_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0] mem [64];
    logic [7:0] wr_log [$];

    always #5 clk = ~clk;

    bp_counter_update_ctrl #(
        .DEPTH(64), .INDEX(6), .CTRW(2), .INIT_VAL(2), .QDEPTH(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (clear_i),
        .fetch_req_i   (fetch_req_i),
        .fetch_idx_i   (fetch_idx_i),
        .pred_valid_o  (pred_valid_o),
        .pred_taken_o  (pred_taken_o),
        .pred_ctr_o    (pred_ctr_o),
        .upd_valid_i   (upd_valid_i),
        .upd_ready_o   (upd_ready_o),
        .upd_idx_i     (upd_idx_i),
        .upd_taken_i   (upd_taken_i),
        .ram_addr0_o   (ram_addr0_o),
        .ram_data0_i   (ram_data0_i),
        .ram_addr0wr_o (ram_addr0wr_o),
        .ram_data0wr_o (ram_data0wr_o),
        .ram_we0_o     (ram_we0_o),
        .init_done_o   (init_done_o)
    );

    // Counter RAM: combinational read, clocked write, with a write log.
    assign ram_data0_i = mem[ram_addr0_o];
    always @(posedge clk) begin
        if (ram_we0_o) begin
            mem[ram_addr0wr_o] <= ram_data0wr_o;
            wr_log.push_back({ram_addr0wr_o, ram_data0wr_o});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] idx, input logic taken);
        upd_valid_i = 1'b1;
        upd_idx_i   = idx;
        upd_taken_i = taken;
        #1;
        chk("push_ready", 32'(upd_ready_o), 32'd1);
        cyc(1);
        upd_valid_i = 1'b0;
    endtask

    task automatic walk(input string tag);
        int bad;
        for (int k = 0; k < 64; k++) begin
            chk(tag, 32'({upd_ready_o, init_done_o, ram_we0_o, ram_addr0wr_o, ram_data0wr_o}),
                32'({1'b0, 1'b0, 1'b1, 6'(k), 2'd2}));
            cyc(1);
        end
        chk({tag, "_done"}, 32'({init_done_o, ram_we0_o, upd_ready_o}), 32'({1'b1, 1'b0, 1'b1}));
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 2'd2) bad++;
        chk({tag, "_mem"}, 32'(bad), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        clear_i     = 1'b0;
        fetch_req_i = 1'b1;
        fetch_idx_i = 6'd0;
        upd_valid_i = 1'b1;
        upd_idx_i   = 6'd0;
        upd_taken_i = 1'b0;

        // Reset held: no writes, no ready, no predictions.
        cyc(3);
        chk("rst_outs", 32'({ram_we0_o, upd_ready_o, init_done_o, pred_valid_o}), 32'd0);

        // Test 1: init walk after reset release.
        fetch_req_i = 1'b0;
        upd_valid_i = 1'b0;
        reset       = 1'b1;
        #1;
        walk("init_walk");

        // Test 2: saturating up then down on idx 5.
        wr_log.delete();
        push(6'd5, 1'b1);
        push(6'd5, 1'b1);
        push(6'd5, 1'b1);
        cyc(8);
        chk("t2_up_n", 32'(wr_log.size()), 32'd3);
        chk("t2_up_w0", 32'(wr_log[0]), 32'({6'd5, 2'd3}));
        chk("t2_up_w1", 32'(wr_log[1]), 32'({6'd5, 2'd3}));
        chk("t2_up_w2", 32'(wr_log[2]), 32'({6'd5, 2'd3}));
        wr_log.delete();
        push(6'd5, 1'b0);
        push(6'd5, 1'b0);
        push(6'd5, 1'b0);
        push(6'd5, 1'b0);
        cyc(10);
        chk("t2_dn_n", 32'(wr_log.size()), 32'd4);
        chk("t2_dn_w0", 32'(wr_log[0]), 32'({6'd5, 2'd2}));
        chk("t2_dn_w1", 32'(wr_log[1]), 32'({6'd5, 2'd1}));
        chk("t2_dn_w2", 32'(wr_log[2]), 32'({6'd5, 2'd0}));
        chk("t2_dn_w3", 32'(wr_log[3]), 32'({6'd5, 2'd0}));
        chk("t2_mem5", 32'(mem[5]), 32'd0);

        // Test 3: fetch holds the read port for 10 cycles; update to idx 9 waits.
        wr_log.delete();
        fetch_req_i = 1'b1;
        fetch_idx_i = 6'd3;
        upd_valid_i = 1'b1;
        upd_idx_i   = 6'd9;
        upd_taken_i = 1'b1;
        #1;
        chk("t3_ready", 32'(upd_ready_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t3_stall", 32'({pred_valid_o, pred_taken_o, pred_ctr_o, ram_we0_o, ram_addr0_o}),
                32'({1'b1, 1'b1, 2'd2, 1'b0, 6'd3}));
            cyc(1);
            upd_valid_i = 1'b0;
            #1;
        end
        fetch_req_i = 1'b0;
        #1;
        chk("t3_rd", 32'({ram_we0_o, ram_addr0_o}), 32'({1'b0, 6'd9}));
        cyc(1);
        chk("t3_wr", 32'({ram_we0_o, ram_addr0wr_o, ram_data0wr_o}), 32'({1'b1, 6'd9, 2'd3}));
        cyc(1);
        chk("t3_mem9", 32'(mem[9]), 32'd3);
        chk("t3_n", 32'(wr_log.size()), 32'd1);
        cyc(3);

        // Test 4: fill the queue while fetch stalls it; 5th push refused.
        wr_log.delete();
        fetch_req_i = 1'b1;
        fetch_idx_i = 6'd0;
        push(6'd10, 1'b1);
        push(6'd11, 1'b0);
        push(6'd12, 1'b1);
        push(6'd13, 1'b0);
        upd_valid_i = 1'b1;
        upd_idx_i   = 6'd14;
        upd_taken_i = 1'b1;
        #1;
        chk("t4_full_ready", 32'({upd_ready_o, ram_we0_o}), 32'd0);
        cyc(1);
        upd_valid_i = 1'b0;
        fetch_req_i = 1'b0;
        cyc(12);
        chk("t4_n", 32'(wr_log.size()), 32'd4);
        chk("t4_w0", 32'(wr_log[0]), 32'({6'd10, 2'd3}));
        chk("t4_w1", 32'(wr_log[1]), 32'({6'd11, 2'd1}));
        chk("t4_w2", 32'(wr_log[2]), 32'({6'd12, 2'd3}));
        chk("t4_w3", 32'(wr_log[3]), 32'({6'd13, 2'd1}));
        chk("t4_mem14", 32'(mem[14]), 32'd2);

        // Test 6: lookup of idx 7 during its own write sees the old value.
        push(6'd7, 1'b1);
        cyc(2);
        fetch_req_i = 1'b1;
        fetch_idx_i = 6'd7;
        #1;
        chk("t6_wr", 32'({ram_we0_o, ram_addr0wr_o, ram_data0wr_o}), 32'({1'b1, 6'd7, 2'd3}));
        chk("t6_old", 32'({pred_valid_o, pred_ctr_o}), 32'({1'b1, 2'd2}));
        cyc(1);
        chk("t6_new", 32'({pred_valid_o, pred_taken_o, pred_ctr_o}), 32'({1'b1, 1'b1, 2'd3}));
        fetch_req_i = 1'b0;
        cyc(3);

        // Test 5: clear during WR with two more entries queued.
        wr_log.delete();
        push(6'd20, 1'b1);
        push(6'd21, 1'b1);
        push(6'd22, 1'b1);
        clear_i = 1'b1;
        #1;
        chk("t5_wr_in_clear", 32'({ram_we0_o, ram_addr0wr_o, ram_data0wr_o}), 32'({1'b1, 6'd20, 2'd3}));
        cyc(1);
        clear_i = 1'b0;
        #1;
        chk("t5_restart", 32'({init_done_o, upd_ready_o}), 32'd0);
        walk("clr_walk");
        wr_log.delete();
        cyc(6);
        chk("t5_q_flushed", 32'(wr_log.size()), 32'd0);
        chk("t5_mem20", 32'(mem[20]), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
